fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with the IF/ID pipeline register.
//
// Holds the fetch PC, presents it to instruction memory, and captures the
// returned word into IF/ID. A redirect from EX replaces the next PC and
// squashes whatever is in IF/ID. Hazard-unit stalls hold the PC and/or IF/ID.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   stallF      hold the fetch PC
//   stallD      hold the IF/ID register
//   flushD      replace IF/ID contents with a bubble
//   pcselE      taken branch/jump resolved in EX
//   targetE     redirect address from EX (low two bits ignored)
//   instrF      instruction word read combinationally at pcF
//   pcF         current fetch PC / instruction memory address
//   pcD         PC of the instruction in decode
//   pcplus4D    pcD + 4
//   instrD      instruction in decode
//   validD      instrD is a real fetched instruction
//   fetch_count number of real instructions loaded into IF/ID since reset
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcselE,
  input  logic [31:0] targetE,
  input  logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic [31:0] instrD,
  output logic        validD,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcplus4d_q, pcplus4d_d;
  logic [31:0] instrd_q, instrd_d;
  logic        validd_q, validd_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pcplus4F;

  assign pcplus4F = pc_q + 32'd4;

  // Redirect wins over stallF so a taken branch is never lost under a stall.
  always_comb begin
    pc_d = pcplus4F;
    if (pcselE) begin
      pc_d = {targetE[31:2], 2'b00};
    end else if (stallF) begin
      pc_d = pc_q;
    end
  end

  // A redirect also squashes IF/ID: the word there was fetched down the
  // wrong path. Flush wins over stallD.
  always_comb begin
    pcd_d      = pcd_q;
    pcplus4d_d = pcplus4d_q;
    instrd_d   = instrd_q;
    validd_d   = validd_q;
    count_d    = count_q;
    if (flushD || pcselE) begin
      pcd_d      = 32'd0;
      pcplus4d_d = 32'd0;
      instrd_d   = NOP_INSTR;
      validd_d   = 1'b0;
    end else if (!stallD) begin
      pcd_d      = pc_q;
      pcplus4d_d = pcplus4F;
      instrd_d   = instrF;
      validd_d   = 1'b1;
      count_d    = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pcd_q      <= 32'd0;
      pcplus4d_q <= 32'd0;
      instrd_q   <= NOP_INSTR;
      validd_q   <= 1'b0;
      count_q    <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      pcd_q      <= pcd_d;
      pcplus4d_q <= pcplus4d_d;
      instrd_q   <= instrd_d;
      validd_q   <= validd_d;
      count_q    <= count_d;
    end
  end

  // All outputs come straight from registers.
  assign pcF         = pc_q;
  assign pcD         = pcd_q;
  assign pcplus4D    = pcplus4d_q;
  assign instrD      = instrd_q;
  assign validD      = validd_q;
  assign fetch_count = count_q;

endmodule
